// File: rtl/coefficient_bank_if.sv
// Coefficient-load link between the loader (master) and the coefficient bank (slave),
// carrying the write strobe, the busy flag and the committed coefficient set.
interface coefficient_bank_if #(
    parameter int DATA_W = 16
);
    logic              load_coeff;
    logic [1:0]        coefficient_num;
    logic [DATA_W-1:0] coeff_data;
    logic              modwait;
    logic [DATA_W-1:0] f0_coeff;
    logic [DATA_W-1:0] f1_coeff;
    logic [DATA_W-1:0] f2_coeff;
    logic [DATA_W-1:0] f3_coeff;
    logic              coeff_valid;
    logic              load_err;

    modport master (
        output load_coeff, coefficient_num, coeff_data,
        input  modwait, f0_coeff, f1_coeff, f2_coeff, f3_coeff, coeff_valid, load_err
    );

    modport slave (
        input  load_coeff, coefficient_num, coeff_data,
        output modwait, f0_coeff, f1_coeff, f2_coeff, f3_coeff, coeff_valid, load_err
    );
endinterface

// File: rtl/coefficient_bank.sv
// Stages four in-order coefficient writes and commits them atomically one cycle after the last busy period.
// Each accepted write holds modwait high for BUSY_CYCLES; strobes while busy or out of order are dropped with a load_err pulse.
module coefficient_bank #(
    parameter int DATA_W      = 16,
    parameter int BUSY_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_n_reset,
    coefficient_bank_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [2:0]        r_cnt;
    logic [1:0]        r_expected;
    logic [DATA_W-1:0] r_stage [4];
    logic [DATA_W-1:0] r_f     [4];
    logic              r_valid;
    logic              r_err;
    logic              r_modwait;

    logic w_accept;
    logic w_cnt_zero;
    logic w_modwait_nxt;
    logic w_err_nxt;
    logic w_exp_clr;
    logic w_exp_inc;
    logic w_commit;

    // COMMIT behaves like IDLE towards new strobes, so only BUSY blocks acceptance.
    assign w_accept   = bus.load_coeff && (r_state != ST_BUSY) && (bus.coefficient_num == r_expected);
    assign w_cnt_zero = (r_cnt == 3'd0);

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // In BUSY, r_expected still holds the index being absorbed; it advances on the final busy edge.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_COMMIT: w_next_state = w_accept ? ST_BUSY : ST_IDLE;
            ST_BUSY: begin
                if (w_cnt_zero) begin
                    w_next_state = (r_expected == 2'd3) ? ST_COMMIT : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_modwait_nxt = (w_next_state == ST_BUSY);
        w_err_nxt     = bus.load_coeff && !w_accept;
        w_exp_clr     = bus.load_coeff && (r_state != ST_BUSY) && !w_accept;
        w_exp_inc     = (r_state == ST_BUSY) && w_cnt_zero;
        w_commit      = (r_state == ST_COMMIT);
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_cnt      <= 3'd0;
            r_expected <= 2'd0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_modwait  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_stage[i] <= '0;
                r_f[i]     <= '0;
            end
        end else begin
            r_modwait <= w_modwait_nxt;
            r_err     <= w_err_nxt;
            if (w_accept) begin
                r_stage[bus.coefficient_num] <= bus.coeff_data;
                r_cnt                        <= 3'(BUSY_CYCLES - 1);
            end else if ((r_state == ST_BUSY) && !w_cnt_zero) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_exp_clr) begin
                r_expected <= 2'd0;
            end else if (w_exp_inc) begin
                r_expected <= r_expected + 2'd1;
            end
            if (w_commit) begin
                for (int i = 0; i < 4; i++) begin
                    r_f[i] <= r_stage[i];
                end
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.modwait     = r_modwait;
    assign bus.load_err    = r_err;
    assign bus.coeff_valid = r_valid;
    assign bus.f0_coeff    = r_f[0];
    assign bus.f1_coeff    = r_f[1];
    assign bus.f2_coeff    = r_f[2];
    assign bus.f3_coeff    = r_f[3];
endmodule

// File: tb/tb_coefficient_bank.sv
// Drives identical strobes into three banks (BUSY_CYCLES 2, 1, 7) and scoreboards every cycle against a timing model.
module tb_coefficient_bank;
    typedef struct packed {
        logic        mw;
        logic        err;
        logic        valid;
        logic [15:0] f0;
        logic [15:0] f1;
        logic [15:0] f2;
        logic [15:0] f3;
    } obs_t;
    typedef obs_t [2:0] trio_t;

    localparam int BC [3] = '{2, 1, 7};

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        ld = 1'b0;
    logic [1:0]  idx = 2'd0;
    logic [15:0] dat = 16'd0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    coefficient_bank_if #(.DATA_W(16)) bus0 ();
    coefficient_bank_if #(.DATA_W(16)) bus1 ();
    coefficient_bank_if #(.DATA_W(16)) bus2 ();

    assign bus0.load_coeff = ld;  assign bus0.coefficient_num = idx;  assign bus0.coeff_data = dat;
    assign bus1.load_coeff = ld;  assign bus1.coefficient_num = idx;  assign bus1.coeff_data = dat;
    assign bus2.load_coeff = ld;  assign bus2.coefficient_num = idx;  assign bus2.coeff_data = dat;

    coefficient_bank #(.DATA_W(16), .BUSY_CYCLES(2)) dut0 (.i_clk(clk), .i_n_reset(n_reset), .bus(bus0));
    coefficient_bank #(.DATA_W(16), .BUSY_CYCLES(1)) dut1 (.i_clk(clk), .i_n_reset(n_reset), .bus(bus1));
    coefficient_bank #(.DATA_W(16), .BUSY_CYCLES(7)) dut2 (.i_clk(clk), .i_n_reset(n_reset), .bus(bus2));

    obs_t act0, act1, act2;
    assign act0 = {bus0.modwait, bus0.load_err, bus0.coeff_valid, bus0.f0_coeff, bus0.f1_coeff, bus0.f2_coeff, bus0.f3_coeff};
    assign act1 = {bus1.modwait, bus1.load_err, bus1.coeff_valid, bus1.f0_coeff, bus1.f1_coeff, bus1.f2_coeff, bus1.f3_coeff};
    assign act2 = {bus2.modwait, bus2.load_err, bus2.coeff_valid, bus2.f0_coeff, bus2.f1_coeff, bus2.f2_coeff, bus2.f3_coeff};

    // Reference model: a write accepted at edge n keeps the bank busy for edges n+1..n+BUSY,
    // and a set completed at edge n becomes visible at edge n+BUSY+1.
    int          edge_n = 0;
    int          last_acc [3];
    int          expi     [3];
    int          pend_due [3];
    bit          valid    [3];
    bit          err      [3];
    logic [15:0] stage    [3][4];
    logic [15:0] pend     [3][4];
    logic [15:0] comm     [3][4];

    trio_t exp_q [$];

    task automatic model_reset(input int k);
        last_acc[k] = -1000;
        expi[k]     = 0;
        pend_due[k] = -1;
        valid[k]    = 1'b0;
        err[k]      = 1'b0;
        for (int j = 0; j < 4; j++) begin
            stage[k][j] = 16'd0;
            pend[k][j]  = 16'd0;
            comm[k][j]  = 16'd0;
        end
    endtask

    task automatic model_step(input int k);
        int d;
        d = edge_n - last_acc[k];
        if (pend_due[k] == edge_n) begin
            for (int j = 0; j < 4; j++) comm[k][j] = pend[k][j];
            valid[k]    = 1'b1;
            pend_due[k] = -1;
        end
        if (ld) begin
            if (d >= 1 && d <= BC[k]) begin
                err[k] = 1'b1;
            end else if (int'(idx) == expi[k]) begin
                stage[k][idx] = dat;
                last_acc[k]   = edge_n;
                expi[k]       = (expi[k] + 1) % 4;
                if (idx == 2'd3) begin
                    for (int j = 0; j < 4; j++) pend[k][j] = stage[k][j];
                    pend_due[k] = edge_n + BC[k] + 1;
                end
            end else begin
                err[k]  = 1'b1;
                expi[k] = 0;
            end
        end
    endtask

    function automatic obs_t expect_of(input int k);
        obs_t o;
        int   d;
        d       = edge_n - last_acc[k];
        o.mw    = (d >= 0) && (d < BC[k]);
        o.err   = err[k];
        o.valid = valid[k];
        o.f0    = comm[k][0];
        o.f1    = comm[k][1];
        o.f2    = comm[k][2];
        o.f3    = comm[k][3];
        return o;
    endfunction

    task automatic tick(input bit rst_assert, input bit rst_release);
        trio_t e;
        @(posedge clk);
        edge_n++;
        for (int k = 0; k < 3; k++) begin
            err[k] = 1'b0;
            if (n_reset) model_step(k);
        end
        #1;
        if (rst_assert) begin
            n_reset = 1'b0;
            for (int k = 0; k < 3; k++) model_reset(k);
        end
        if (rst_release) n_reset = 1'b1;
        for (int k = 0; k < 3; k++) e[k] = expect_of(k);
        exp_q.push_back(e);
        ld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic strobe(input logic [1:0] i, input logic [15:0] d);
        ld  = 1'b1;
        idx = i;
        dat = d;
        tick(1'b0, 1'b0);
    endtask

    task automatic chk(input int k, input obs_t a, input obs_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL cfg%0d(busy=%0d) cycle %0d: got mw=%b err=%b vld=%b f=%h/%h/%h/%h, want mw=%b err=%b vld=%b f=%h/%h/%h/%h",
                     k, BC[k], edge_n, a.mw, a.err, a.valid, a.f0, a.f1, a.f2, a.f3,
                     e.mw, e.err, e.valid, e.f0, e.f1, e.f2, e.f3);
        end
    endtask

    always @(negedge clk) begin
        trio_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(0, act0, e[0]);
            chk(1, act1, e[1]);
            chk(2, act2, e[2]);
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) model_reset(k);

        // Reset held, released, then quiet.
        idle(2);
        tick(1'b0, 1'b1);
        idle(5);

        // In-order set, each strobe after modwait falls for the 2-cycle bank.
        strobe(2'd0, 16'h0001); idle(2);
        strobe(2'd1, 16'h0020); idle(2);
        strobe(2'd2, 16'h0300); idle(2);
        strobe(2'd3, 16'h4000); idle(3);

        // Out-of-order idx2 after idx0, then a fresh full set.
        strobe(2'd0, 16'h5555); idle(2);
        strobe(2'd2, 16'h6666); idle(2);
        strobe(2'd0, 16'hAAAA); idle(2);
        strobe(2'd1, 16'hBBBB); idle(2);
        strobe(2'd2, 16'hCCCC); idle(2);
        strobe(2'd3, 16'hDDDD); idle(3);

        // Strobe one cycle into a busy period, then resume the set.
        strobe(2'd0, 16'h1111);
        strobe(2'd1, 16'h9999);
        idle(1);
        strobe(2'd1, 16'h1234); idle(2);
        strobe(2'd2, 16'h2222); idle(2);
        strobe(2'd3, 16'h3333); idle(3);

        // Reset while idx2 is being absorbed, stray idx3, then a full set.
        strobe(2'd0, 16'h0A0A); idle(2);
        strobe(2'd1, 16'h0B0B); idle(2);
        strobe(2'd2, 16'h0C0C);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        strobe(2'd3, 16'h0D0D); idle(2);
        strobe(2'd0, 16'h7001); idle(2);
        strobe(2'd1, 16'h7002); idle(2);
        strobe(2'd2, 16'h7003); idle(2);
        strobe(2'd3, 16'h7004); idle(3);

        // Slow in-order traffic so the 7-cycle bank also commits.
        for (int i = 0; i < 16; i++) begin
            strobe(2'(expi[2]), 16'($urandom));
            idle($urandom_range(6, 9));
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 700; i++) begin
            int r;
            int c;
            r = $urandom_range(0, 99);
            c = $urandom_range(0, 2);
            if (r < 2) begin
                tick(1'b1, 1'b0);
                tick(1'b0, 1'b1);
            end else if (r < 40) begin
                strobe(2'(expi[c]), 16'($urandom));
            end else if (r < 48) begin
                strobe(2'($urandom_range(0, 3)), 16'($urandom));
            end else begin
                tick(1'b0, 1'b0);
            end
        end

        idle(4);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/coefficient_bank.md
Name: coefficient_bank

Overview:
- Responder end of the coefficient-load interface. Accepts the load_coeff / coefficient_num strobes from the coefficient loader and captures the matching coefficient word into a staging register.
- Holds modwait high while each write is being absorbed.
- Commits all four coefficients atomically to the FIR datapath once index 3 has been written in order.
- Sits between the coefficient loader and the FIR multiply-accumulate datapath.

Parameters:
- DATA_W, 16, width of one coefficient word.
- BUSY_CYCLES, 2, number of cycles modwait stays high per accepted write (legal range 1..7).

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_reset  input  1  asynchronous active-low reset
- load_coeff  input  1  single-cycle write strobe from the loader
- coefficient_num  input  2  coefficient index for this strobe
- coeff_data  input  DATA_W  coefficient word, valid while load_coeff=1
- modwait  output  1  busy flag back to the loader
- f0_coeff  output  DATA_W  committed coefficient 0
- f1_coeff  output  DATA_W  committed coefficient 1
- f2_coeff  output  DATA_W  committed coefficient 2
- f3_coeff  output  DATA_W  committed coefficient 3
- coeff_valid  output  1  sticky; 1 once a full set has been committed
- load_err  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (asynchronous, n_reset=0):
  - modwait=0, f0..f3=0, coeff_valid=0, load_err=0.
  - Staging registers cleared to 0, expected index=0, busy counter=0, state=IDLE.
  - Reset asserted mid-load aborts the load. No partial commit.
- State IDLE:
  - On the edge sampling load_coeff=1 with coefficient_num==expected, write coeff_data into stage[coefficient_num].
  - Load busy counter with BUSY_CYCLES-1 and go to BUSY. modwait=1 from that edge.
- State BUSY:
  - modwait=1. Counter decrements each cycle.
  - At the edge where the counter is 0: modwait goes to 0 and expected increments (wraps 3->0).
  - If the index written was 3, go to COMMIT; otherwise return to IDLE.
  - Net effect: modwait is high for exactly BUSY_CYCLES cycles per accepted write.
- State COMMIT (one cycle):
  - f0..f3 <= stage[0..3] simultaneously; coeff_valid <= 1; return to IDLE. modwait=0.
  - A load_coeff arriving in this cycle is handled as in IDLE (expected=0).
- Out-of-order strobe (IDLE, coefficient_num!=expected):
  - No staging write, no modwait.
  - load_err=1 for the next cycle only. expected resets to 0.
  - Committed outputs and coeff_valid are unchanged.
- Strobe while in BUSY:
  - Ignored (no write, counter unaffected). load_err pulses 1 cycle.
  - expected is not reset, so the in-flight load still completes normally.
- Simultaneous events: a strobe on the same edge the counter reaches 0 counts as "while BUSY" and is ignored with an error.
- Committed outputs change only in COMMIT. The datapath never sees a mixed old/new set.
- A second full set overwrites all four outputs at its COMMIT. coeff_valid stays 1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then idle 5 cycles -> modwait=0, f0..f3=0x0000, coeff_valid=0, load_err=0.
- In-order loads idx0..3 with data 0x0001, 0x0020, 0x0300, 0x4000, each strobe issued after modwait falls (BUSY_CYCLES=2) -> modwait high exactly 2 cycles per strobe; one cycle after the last modwait falls, f0..f3=0x0001/0x0020/0x0300/0x4000 and coeff_valid=1. Outputs stay 0 until then.
- After a committed set, load idx0 then idx2 -> load_err=1 for one cycle after the idx2 strobe, no modwait for it; outputs unchanged. Follow with idx0..3 = 0xAAAA..0xDDDD -> new set commits.
- Strobe idx1 one cycle into the BUSY period of idx0 -> load_err pulse, modwait still falls 2 cycles after the idx0 strobe. Next strobe idx1=0x1234 is accepted; stage[1]=0x1234 at commit.
- Assert n_reset after idx2 is accepted while modwait=1 -> all outputs 0 immediately. A subsequent idx3 strobe raises load_err, and a full 0..3 sequence is then required to commit.
- Parameter sweep BUSY_CYCLES=1 and 7 -> modwait high exactly 1 and 7 cycles respectively per accepted write.
